// File: rtl/systolic_mac4.sv
// 4x4 output-stationary systolic MAC array fed by two skewed (dripper) streams.
// Optional macro SYSTOLIC_SAT_EN: signed operands with saturating accumulation.
module systolic_mac4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] a4,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] b3,
    input  logic [WIDTH-1:0] b4,
    input  logic [1:0]       rd_row,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] c3,
    output logic [WIDTH-1:0] c4
);

    localparam int N = 4;
    localparam logic [3:0] LAST_CYCLE = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             running;
    logic [3:0]       cnt;

    logic [WIDTH-1:0] a_edge [N];
    logic [WIDTH-1:0] b_edge [N];
    logic [WIDTH-1:0] a_in   [N][N];
    logic [WIDTH-1:0] b_in   [N][N];
    logic [WIDTH-1:0] a_pass [N][N-1];
    logic [WIDTH-1:0] b_pass [N-1][N];
    logic [WIDTH-1:0] acc    [N][N];
    logic [WIDTH-1:0] c_row  [N];

`ifdef SYSTOLIC_SAT_EN
    function automatic logic [WIDTH-1:0] mac_step(
        input logic [WIDTH-1:0] acc_v,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v
    );
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH:0]   sum;
        logic signed [2*WIDTH:0]   max_v;
        logic signed [2*WIDTH:0]   min_v;
        prod  = $signed(a_v) * $signed(b_v);
        sum   = {{(WIDTH+1){acc_v[WIDTH-1]}}, acc_v} + {prod[2*WIDTH-1], prod};
        max_v = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
        min_v = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
        if (sum > max_v)
            mac_step = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sum < min_v)
            mac_step = {1'b1, {(WIDTH-1){1'b0}}};
        else
            mac_step = sum[WIDTH-1:0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] mac_step(
        input logic [WIDTH-1:0] acc_v,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v
    );
        logic [WIDTH-1:0] prod;
        prod     = a_v * b_v;
        mac_step = acc_v + prod;
    endfunction
`endif

    assign a_edge[0] = a1;
    assign a_edge[1] = a2;
    assign a_edge[2] = a3;
    assign a_edge[3] = a4;
    assign b_edge[0] = b1;
    assign b_edge[1] = b2;
    assign b_edge[2] = b3;
    assign b_edge[3] = b4;

    // Edge PEs read the ports; interior PEs read their neighbour's pass register.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_edge[gi];
            end else begin : g_a_pass
                assign a_in[gi][gj] = a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_edge[gj];
            end else begin : g_b_pass
                assign b_in[gi][gj] = b_pass[gi-1][gj];
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST_CYCLE)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign running = (state == RUN);
    assign busy    = running;
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= 4'd0;
            else if (running)
                cnt <= cnt + 4'd1;
        end
    end

    // Readback is cleared together with the accumulators so a restart never shows stale results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                c_row[i] <= '0;
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
                for (int j = 0; j < N-1; j++) a_pass[i][j] <= '0;
            end
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) b_pass[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                c_row[i] <= '0;
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
                for (int j = 0; j < N-1; j++) a_pass[i][j] <= '0;
            end
            for (int i = 0; i < N-1; i++)
                for (int j = 0; j < N; j++) b_pass[i][j] <= '0;
        end else begin
            if (running) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= mac_step(acc[i][j], a_in[i][j], b_in[i][j]);
                    for (int j = 0; j < N-1; j++) a_pass[i][j] <= a_in[i][j];
                end
                for (int i = 0; i < N-1; i++)
                    for (int j = 0; j < N; j++) b_pass[i][j] <= b_in[i][j];
            end
            for (int j = 0; j < N; j++) c_row[j] <= acc[rd_row][j];
        end
    end

    assign c1 = c_row[0];
    assign c2 = c_row[1];
    assign c3 = c_row[2];
    assign c4 = c_row[3];

endmodule

// File: tb/tb_systolic_mac4.sv
// Self-checking bench for systolic_mac4: directed table plus random matrices vs. a matrix-product model.
module tb_systolic_mac4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_d [4];
    logic [31:0] b_d [4];
    logic [1:0]  rd_row;
    logic        busy;
    logic        done;
    logic [31:0] c1, c2, c3, c4;

    int n_cmp;
    int n_bad;

    logic [31:0] mA    [4][4];
    logic [31:0] mB    [4][4];
    logic [31:0] exp_c [4][4];

    typedef struct {
        string              name;
        logic [15:0][31:0]  a;
        logic [15:0][31:0]  b;
        logic [15:0][31:0]  c;
    } vec_t;

    vec_t tbl [$];

    systolic_mac4 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a1(a_d[0]), .a2(a_d[1]), .a3(a_d[2]), .a4(a_d[3]),
        .b1(b_d[0]), .b2(b_d[1]), .b3(b_d[2]), .b4(b_d[3]),
        .rd_row(rd_row), .busy(busy), .done(done),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Plain matrix product C = A x B in the arithmetic the build selects.
    task automatic model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
`ifdef SYSTOLIC_SAT_EN
                longint s;
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s = s + longint'($signed(mA[i][k])) * longint'($signed(mB[k][j]));
                    if (s > 64'sd2147483647) s = 64'sd2147483647;
                    if (s < -64'sd2147483648) s = -64'sd2147483648;
                end
                exp_c[i][j] = s[31:0];
`else
                logic [31:0] s;
                s = 0;
                for (int k = 0; k < 4; k++) s = s + mA[i][k] * mB[k][j];
                exp_c[i][j] = s;
`endif
            end
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < 4; i++) begin
            a_d[i] = '0;
            b_d[i] = '0;
        end
    endtask

    // Start, drip mA/mB with the skew contract for 10 RUN cycles; optional start pulse or reset inside RUN.
    task automatic drip_run(input string name, input int start_at, input int abort_at);
        @(negedge clk);
        start = 1'b1;
        zero_inputs();
        @(negedge clk);
        start = 1'b0;
        chk({name, "_start_clear_c1"}, c1, 32'd0);
        chk({name, "_start_clear_c4"}, c4, 32'd0);
        for (int c = 0; c < 10; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({name, "_abort_busy"}, {31'd0, busy}, 32'd0);
                chk({name, "_abort_done"}, {31'd0, done}, 32'd0);
                chk({name, "_abort_c1"}, c1, 32'd0);
                chk({name, "_abort_c2"}, c2, 32'd0);
                chk({name, "_abort_c3"}, c3, 32'd0);
                chk({name, "_abort_c4"}, c4, 32'd0);
                zero_inputs();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
                chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
                return;
            end
            for (int i = 0; i < 4; i++) begin
                int k;
                k = c - i;
                a_d[i] = (k >= 0 && k < 4) ? mA[i][k] : 32'd0;
                b_d[i] = (k >= 0 && k < 4) ? mB[k][i] : 32'd0;
            end
            start = (c == start_at);
            chk($sformatf("%s_busy_c%0d", name, c), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_notdone_c%0d", name, c), {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        start = 1'b0;
        zero_inputs();
        chk({name, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_end_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic read_all(input string name);
        for (int r = 0; r < 4; r++) begin
            rd_row = r[1:0];
            @(negedge clk);
            chk($sformatf("%s_r%0d_c1", name, r), c1, exp_c[r][0]);
            chk($sformatf("%s_r%0d_c2", name, r), c2, exp_c[r][1]);
            chk($sformatf("%s_r%0d_c3", name, r), c3, exp_c[r][2]);
            chk($sformatf("%s_r%0d_c4", name, r), c4, exp_c[r][3]);
            chk($sformatf("%s_r%0d_done", name, r), {31'd0, done}, 32'd1);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                mA[i][k]    = v.a[i*4+k];
                mB[i][k]    = v.b[i*4+k];
                exp_c[i][k] = v.c[i*4+k];
            end
    endtask

    task automatic set_const(input logic [31:0] av, input logic [31:0] bv);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                mA[i][k] = av;
                mB[i][k] = bv;
            end
    endtask

    initial begin
        vec_t v;
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        rd_row = 2'd0;
        zero_inputs();

        v.name = "identity";
        for (int n = 0; n < 16; n++) begin
            v.a[n] = (n / 4 == n % 4) ? 32'd1 : 32'd0;
            v.b[n] = n + 1;
            v.c[n] = n + 1;
        end
        tbl.push_back(v);
        v.name = "uniform";
        for (int n = 0; n < 16; n++) begin
            v.a[n] = 32'd2;
            v.b[n] = 32'd3;
            v.c[n] = 32'h18;
        end
        tbl.push_back(v);
        v.name = "wrap_sat";
        for (int n = 0; n < 16; n++) begin
            v.a[n] = 32'd0;
            v.b[n] = 32'd0;
            v.c[n] = 32'd0;
        end
        v.a[0] = 32'h0001_0000;
        v.b[0] = 32'h0001_0000;
`ifdef SYSTOLIC_SAT_EN
        v.c[0] = 32'h7FFF_FFFF;
`else
        v.c[0] = 32'h0000_0000;
`endif
        tbl.push_back(v);
        v.name = "neg_times_five";
        v.a[0] = 32'hFFFF_FFFF;
        v.b[0] = 32'd5;
        v.c[0] = 32'hFFFF_FFFB;
        tbl.push_back(v);

        #13;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_c1", c1, 32'd0);
        chk("reset_c3", c3, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        foreach (tbl[n]) begin
            load_vec(tbl[n]);
            drip_run(tbl[n].name, -1, -1);
            read_all(tbl[n].name);
        end

        // Restart from DONE holding identity results: old values must not carry over.
        load_vec(tbl[0]);
        drip_run("ident_pre", -1, -1);
        read_all("ident_pre");
        set_const(32'd1, 32'd1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) exp_c[i][j] = 32'd4;
        rd_row = 2'd3;
        drip_run("restart", -1, -1);
        read_all("restart");

        // A start pulse inside RUN is ignored.
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                mA[i][k] = $urandom_range(0, 255);
                mB[i][k] = $urandom_range(0, 255);
            end
        model();
        drip_run("start_in_run", 4, -1);
        read_all("start_in_run");

        // Reset in RUN cycle 5, then a clean identity run.
        load_vec(tbl[0]);
        drip_run("abort", -1, 5);
        load_vec(tbl[0]);
        drip_run("after_abort", -1, -1);
        read_all("after_abort");

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    mA[i][k] = (t < 3) ? $urandom : $urandom_range(0, 65535);
                    mB[i][k] = (t < 3) ? $urandom : $urandom_range(0, 65535);
                end
            model();
            drip_run($sformatf("rand%0d", t), -1, -1);
            read_all($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
